// File: rtl/apb_timeout_demux.sv
// APB 1:N address demux with unmapped-access and subordinate-timeout termination.
// Errors are answered with pslverr so the upstream manager never stalls.
package apb_timeout_demux_pkg;
    typedef struct packed {
        logic [31:0] paddr;
        logic [2:0]  pprot;
        logic        psel;
        logic        penable;
        logic        pwrite;
        logic [31:0] pwdata;
        logic [3:0]  pstrb;
    } apb_req_t;

    typedef struct packed {
        logic        pready;
        logic [31:0] prdata;
        logic        pslverr;
    } apb_rsp_t;
endpackage

module apb_timeout_demux #(
    parameter int unsigned          NumSub        = 4,
    parameter int unsigned          AddrWidth     = 32,
    parameter logic [AddrWidth-1:0] BaseAddr      = 32'h2000_0000,
    parameter int unsigned          RegionBits    = 12,
    parameter int unsigned          TimeoutCycles = 255,
    parameter type apb_req_t = apb_timeout_demux_pkg::apb_req_t,
    parameter type apb_rsp_t = apb_timeout_demux_pkg::apb_rsp_t,
    localparam int unsigned IdxW = (NumSub > 1) ? $clog2(NumSub) : 1
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  apb_req_t               apb_req_i,
    output apb_rsp_t               apb_rsp_o,
    output apb_req_t [NumSub-1:0]  apb_req_o,
    input  apb_rsp_t [NumSub-1:0]  apb_rsp_i,
    output logic                   timeout_o,
    output logic                   unmapped_o,
    output logic [IdxW-1:0]        err_idx_o
);

    localparam int unsigned CntW =
        (TimeoutCycles > 0) ? $clog2(TimeoutCycles + 1) : 1;
    localparam logic [CntW-1:0] CntMax = CntW'(TimeoutCycles);

    typedef enum logic {IDLE, ACCESS} state_e;

    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [IdxW-1:0] err_idx_q, err_idx_d;

    logic [AddrWidth-1:0] off;
    logic [AddrWidth-1:0] idx_full;
    logic [IdxW-1:0]      idx;
    logic                 mapped;
    logic                 sel;
    logic                 en;
    apb_rsp_t             sub_rsp;

    assign off      = apb_req_i.paddr - BaseAddr;
    assign idx_full = off >> RegionBits;
    assign idx      = idx_full[IdxW-1:0];
    assign mapped   = (apb_req_i.paddr >= BaseAddr)
                   && (idx_full < AddrWidth'(NumSub));
    assign sub_rsp  = mapped ? apb_rsp_i[idx] : '0;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        err_idx_d  = err_idx_q;
        sel        = 1'b0;
        en         = 1'b0;
        apb_rsp_o  = '0;
        timeout_o  = 1'b0;
        unmapped_o = 1'b0;
        // Reset also silences the combinational paths, not just the flops.
        if (rst_ni) begin
            unique case (state_q)
                IDLE: begin
                    if (apb_req_i.psel) begin
                        sel     = 1'b1;
                        cnt_d   = '0;
                        state_d = ACCESS;
                    end
                end
                ACCESS: begin
                    state_d = IDLE;
                    if (apb_req_i.psel && !mapped) begin
                        apb_rsp_o.pready  = 1'b1;
                        apb_rsp_o.pslverr = 1'b1;
                        unmapped_o        = 1'b1;
                    end else if (apb_req_i.psel && sub_rsp.pready) begin
                        sel       = 1'b1;
                        en        = apb_req_i.penable;
                        apb_rsp_o = sub_rsp;
                    end else if (apb_req_i.psel && TimeoutCycles != 0
                                 && cnt_q == CntMax) begin
                        apb_rsp_o.pready  = 1'b1;
                        apb_rsp_o.pslverr = 1'b1;
                        timeout_o         = 1'b1;
                        err_idx_d         = idx;
                    end else if (apb_req_i.psel) begin
                        sel       = 1'b1;
                        en        = apb_req_i.penable;
                        apb_rsp_o = sub_rsp;
                        state_d   = ACCESS;
                        if (cnt_q < CntMax) begin
                            cnt_d = cnt_q + CntW'(1);
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        for (int unsigned i = 0; i < NumSub; i++) begin
            apb_req_o[i]         = apb_req_i;
            apb_req_o[i].psel    = sel && mapped && (idx == IdxW'(i));
            apb_req_o[i].penable = en && mapped && (idx == IdxW'(i));
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            err_idx_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            err_idx_q <= err_idx_d;
        end
    end

    assign err_idx_o = err_idx_q;

endmodule

// File: tb/tb_apb_timeout_demux.sv
// Directed bench for apb_timeout_demux with a transaction-level reference model.
// Four subordinates, 4 KiB regions at 0x2000_0000, timeout after 3 wait cycles.
module tb_apb_timeout_demux;
    import apb_timeout_demux_pkg::*;

    localparam int          TO   = 3;
    localparam logic [31:0] BASE = 32'h2000_0000;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    apb_req_t       req;
    apb_rsp_t       rsp;
    apb_req_t [3:0] sreq;
    apb_rsp_t [3:0] srsp;
    logic           to_o;
    logic           um_o;
    logic [1:0]     eidx;

    int vectors = 0;
    int miscompares = 0;

    int          waits [4];
    logic [31:0] rdat  [4];
    logic        serr  [4];
    int          acc   [4];
    logic [3:0]  selv;
    logic [3:0]  env;

    always #5 clk = ~clk;

    apb_timeout_demux #(
        .NumSub(4),
        .AddrWidth(32),
        .BaseAddr(BASE),
        .RegionBits(12),
        .TimeoutCycles(TO)
    ) dut (
        .clk_i(clk),
        .rst_ni(rst_n),
        .apb_req_i(req),
        .apb_rsp_o(rsp),
        .apb_req_o(sreq),
        .apb_rsp_i(srsp),
        .timeout_o(to_o),
        .unmapped_o(um_o),
        .err_idx_o(eidx)
    );

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            selv[i] = sreq[i].psel;
            env[i]  = sreq[i].penable;
        end
    end

    // Subordinates: ready once they have seen waits[i] un-ready ACCESS cycles.
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            srsp[i].pready  = (acc[i] >= waits[i]);
            srsp[i].prdata  = rdat[i];
            srsp[i].pslverr = serr[i];
        end
    end

    always @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (sreq[i].psel && sreq[i].penable && !srsp[i].pready)
                acc[i] <= acc[i] + 1;
            else
                acc[i] <= 0;
        end
    end

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     nm, act, exp, $time);
        end
    endtask

    // Reference model: a transfer is a SETUP followed by ACCESS cycles 1,2,...
    bit         m_acc = 1'b0;
    int         m_n = 0;
    logic [1:0] m_eidx = 2'd0;

    always @(negedge clk) begin : model
        logic [3:0]  es;
        logic [3:0]  ee;
        logic        er;
        logic        eerr;
        logic [31:0] ed;
        logic        et;
        logic        eu;
        logic        mp;
        int          tg;
        logic [1:0]  nidx;
        es = '0; ee = '0; er = 1'b0; eerr = 1'b0;
        ed = '0; et = 1'b0; eu = 1'b0;
        mp = (req.paddr >= BASE) && (req.paddr < BASE + 32'h4000);
        tg = mp ? int'((req.paddr - BASE) / 4096) : 0;
        nidx = m_eidx;
        if (!rst_n) begin
            m_acc = 1'b0;
            m_eidx = 2'd0;
            nidx = 2'd0;
        end else if (!m_acc) begin
            if (req.psel) begin
                if (mp) es = 4'b1 << tg;
                m_acc = 1'b1;
                m_n = 1;
            end
        end else if (!req.psel) begin
            m_acc = 1'b0;
        end else if (!mp) begin
            er = 1'b1; eerr = 1'b1; eu = 1'b1;
            m_acc = 1'b0;
        end else if (srsp[tg].pready) begin
            es = 4'b1 << tg;
            ee = req.penable ? es : 4'b0;
            er = 1'b1;
            eerr = srsp[tg].pslverr;
            ed = srsp[tg].prdata;
            m_acc = 1'b0;
        end else if (m_n == TO + 1) begin
            er = 1'b1; eerr = 1'b1; et = 1'b1;
            nidx = 2'(tg);
            m_acc = 1'b0;
        end else begin
            es = 4'b1 << tg;
            ee = req.penable ? es : 4'b0;
            m_n++;
        end
        chk("psel", selv, es);
        chk("penable", env, ee);
        chk("pready", rsp.pready, er);
        if (er || !rst_n) begin
            chk("pslverr", rsp.pslverr, eerr);
            chk("prdata", rsp.prdata, ed);
        end
        chk("timeout_o", to_o, et);
        chk("unmapped_o", um_o, eu);
        chk("err_idx_o", eidx, m_eidx);
        if (rst_n) begin
            for (int i = 0; i < 4; i++)
                chk("bcast", {sreq[i].paddr, sreq[i].pwdata},
                    {req.paddr, req.pwdata});
            chk("bcast_ctl", {sreq[3].pwrite, sreq[3].pstrb, sreq[3].pprot},
                {req.pwrite, req.pstrb, req.pprot});
        end
        m_eidx = nidx;
    end

    // Called at posedge+1; returns at posedge+1 with psel low.
    task automatic xfer(input logic [31:0] a, input logic w,
                        input logic [31:0] wd, output logic [31:0] rd,
                        output logic err, output int n, output logic t,
                        output logic u, output logic [3:0] sv);
        bit done;
        req.paddr = a; req.pwrite = w; req.pwdata = wd;
        req.pstrb = 4'hF; req.pprot = 3'd0;
        req.psel = 1'b1; req.penable = 1'b0;
        @(posedge clk); #1;
        req.penable = 1'b1;
        n = 0; done = 1'b0; rd = '0; err = 1'b0;
        t = 1'b0; u = 1'b0; sv = '0;
        for (int k = 0; k < 20 && !done; k++) begin
            #2;
            n++;
            sv = selv;
            if (rsp.pready) begin
                rd = rsp.prdata; err = rsp.pslverr;
                t = to_o; u = um_o;
                done = 1'b1;
            end else begin
                @(posedge clk); #1;
            end
        end
        if (!done) chk("xfer_hang", 64'd1, 64'd0);
        @(posedge clk); #1;
        req.psel = 1'b0; req.penable = 1'b0;
    endtask

    logic [31:0] rd;
    logic        err;
    int          n;
    logic        t;
    logic        u;
    logic [3:0]  sv;

    initial begin
        req = '0;
        for (int i = 0; i < 4; i++) begin
            waits[i] = 0; rdat[i] = 32'h0; serr[i] = 1'b0;
        end
        req.psel = 1'b1;
        req.paddr = 32'h2000_1000;
        #2;
        chk("rst_psel", selv, 4'b0);
        chk("rst_rsp", rsp, 64'd0);
        chk("rst_flags", {to_o, um_o, eidx}, 64'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        req.psel = 1'b0;

        waits[1] = 0;
        xfer(32'h2000_1004, 1'b1, 32'hDEAD_BEEF, rd, err, n, t, u, sv);
        chk("wr_err", err, 0);
        chk("wr_nacc", n, 1);
        chk("wr_sel", sv, 4'b0010);
        chk("wr_to", t, 0);

        waits[3] = 3; rdat[3] = 32'h1234_5678;
        xfer(32'h2000_3000, 1'b0, 32'h0, rd, err, n, t, u, sv);
        chk("rd3_data", rd, 32'h1234_5678);
        chk("rd3_err", err, 0);
        chk("rd3_nacc", n, 4);
        chk("rd3_to", t, 0);

        rdat[0] = 32'hFFFF_0000; rdat[1] = 32'h1111_2222;
        xfer(32'h1FFF_FFFC, 1'b0, 32'h0, rd, err, n, t, u, sv);
        chk("um_lo", {rd, err, u, sv}, {32'h0, 1'b1, 1'b1, 4'b0});
        chk("um_lo_nacc", n, 1);
        xfer(32'h2000_4000, 1'b0, 32'h0, rd, err, n, t, u, sv);
        chk("um_hi", {rd, err, u, sv}, {32'h0, 1'b1, 1'b1, 4'b0});
        chk("um_hi_nacc", n, 1);

        waits[2] = 1000; rdat[2] = 32'hAAAA_5555;
        xfer(32'h2000_2008, 1'b0, 32'h0, rd, err, n, t, u, sv);
        chk("to_rsp", {rd, err, t, u}, {32'h0, 1'b1, 1'b1, 1'b0});
        chk("to_nacc", n, 4);
        chk("to_sel", sv, 4'b0);
        #2;
        chk("to_eidx", eidx, 2);

        waits[0] = 3; rdat[0] = 32'h0BAD_F00D;
        xfer(32'h2000_0000, 1'b0, 32'h0, rd, err, n, t, u, sv);
        chk("race_rsp", {rd, err, t}, {32'h0BAD_F00D, 1'b0, 1'b0});
        chk("race_nacc", n, 4);
        chk("race_eidx", eidx, 2);

        waits[1] = 1; serr[1] = 1'b1; rdat[1] = 32'h5A5A_0001;
        xfer(32'h2000_1FFC, 1'b0, 32'h0, rd, err, n, t, u, sv);
        chk("slv_rsp", {rd, err, t}, {32'h5A5A_0001, 1'b1, 1'b0});
        chk("slv_nacc", n, 2);
        serr[1] = 1'b0;

        waits[0] = 0;
        req.paddr = 32'h2000_0010; req.pwrite = 1'b0;
        req.psel = 1'b1; req.penable = 1'b1;
        #2;
        chk("viol_sel", selv, 4'b0001);
        chk("viol_en", env, 4'b0);
        @(posedge clk); #3;
        chk("viol_rdy", rsp.pready, 1);
        @(posedge clk); #1;
        req.psel = 1'b0; req.penable = 1'b0;

        waits[3] = 1000;
        req.paddr = 32'h2000_3004; req.psel = 1'b1; req.penable = 1'b0;
        @(posedge clk); #1;
        req.penable = 1'b1;
        @(posedge clk); #1;
        req.psel = 1'b0; req.penable = 1'b0;
        #2;
        chk("drop_sel", selv, 4'b0);
        chk("drop_flags", {to_o, um_o}, 0);
        @(posedge clk); #1;

        waits[1] = 1000;
        req.paddr = 32'h2000_1000; req.pwrite = 1'b1;
        req.psel = 1'b1; req.penable = 1'b0;
        @(posedge clk); #1;
        req.penable = 1'b1;
        @(posedge clk); #3;
        chk("pre_rst_sel", selv, 4'b0010);
        rst_n = 1'b0;
        #1;
        chk("rst_mid_sel", selv, 4'b0);
        chk("rst_mid_rdy", rsp.pready, 0);
        chk("rst_mid_eidx", eidx, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        req.psel = 1'b0; req.penable = 1'b0;
        waits[1] = 0;
        xfer(32'h2000_1008, 1'b1, 32'hCAFE_0001, rd, err, n, t, u, sv);
        chk("post_rst", {err, t, sv}, {1'b0, 1'b0, 4'b0010});
        chk("post_rst_nacc", n, 1);

        repeat (2) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
